// File: rtl/picomips_pkg.sv
// Shared types and instruction-field constants for the picoMips front end.
package picomips_pkg;

  typedef enum logic [1:0] {STG_FETCH, STG_DECODE, STG_EXEC, STG_WB} stage_t;

  localparam int INSTR_WIDTH = 13;

  localparam int FUNC_MSB = 12;
  localparam int FUNC_LSB = 6;
  localparam int IMM_MSB  = 5;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop level synchroniser with synchronous active-high reset.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (reset) chain_q <= '0;
    else       chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/fetch_sequencer.sv
// picoMips fetch sequencer: PC, 4-phase stage counter, instruction register,
// handshake synchroniser, wrap pulse and saturating retired-instruction count.
module fetch_sequencer #(
  parameter int PC_WIDTH    = 5,
  parameter int INSTR_WIDTH = 13,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   HandshakeIn,
  input  logic                   PCHold,
  input  logic [INSTR_WIDTH-1:0] ProgData,
  output logic [PC_WIDTH-1:0]    ProgAddr,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic [1:0]             Stage,
  output logic                   Handshake,
  output logic                   Wrap,
  output logic [COUNT_WIDTH-1:0] Retired
);
  import picomips_pkg::*;

  stage_t                 stage_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   wrap_q;
  logic [COUNT_WIDTH-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q   <= STG_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      wrap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      stage_q <= stage_t'(stage_q + 2'd1);
      wrap_q  <= 1'b0;
      if (stage_q == STG_FETCH) instr_q <= ProgData;
      // PCHold is only meaningful on the writeback edge; a hold re-fetches the same word.
      if (stage_q == STG_WB && !PCHold) begin
        pc_q   <= pc_q + PC_WIDTH'(1);
        wrap_q <= (pc_q == '1);
        if (retired_q != '1) retired_q <= retired_q + COUNT_WIDTH'(1);
      end
    end
  end

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_hs_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (HandshakeIn),
    .q_o   (Handshake)
  );

  assign ProgAddr    = pc_q;
  assign Instruction = instr_q;
  assign Stage       = stage_q;
  assign Wrap        = wrap_q;
  assign Retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (COUNT_WIDTH=4 build so saturation is reachable).
module tb_fetch_sequencer;
  localparam int PW = 5;
  localparam int IW = 13;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          HandshakeIn;
  logic          PCHold;
  logic [IW-1:0] ProgData;
  logic [PW-1:0] ProgAddr;
  logic [IW-1:0] Instruction;
  logic [1:0]    Stage;
  logic          Handshake;
  logic          Wrap;
  logic [CW-1:0] Retired;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .SYNC_STAGES(2), .COUNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .HandshakeIn (HandshakeIn),
    .PCHold      (PCHold),
    .ProgData    (ProgData),
    .ProgAddr    (ProgAddr),
    .Instruction (Instruction),
    .Stage       (Stage),
    .Handshake   (Handshake),
    .Wrap        (Wrap),
    .Retired     (Retired)
  );

  always #5 clk = ~clk;

  // ROM contents: word i holds i+100
  assign ProgData = IW'(ProgAddr) + IW'(100);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic wrap_seen;

  initial begin
    reset = 1'b1; PCHold = 1'b0; HandshakeIn = 1'b0;
    tick(); tick();
    chk("rst_stage", Stage, 0);
    chk("rst_pc", ProgAddr, 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_hs", Handshake, 0);
    chk("rst_wrap", Wrap, 0);
    chk("rst_ret", Retired, 0);

    // free run: after k edges Stage=k%4, PC=k/4, Instruction=100+(k-1)/4
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("run_stage", Stage, k % 4);
      chk("run_pc", ProgAddr, k / 4);
      chk("run_instr", Instruction, 100 + (k - 1) / 4);
      chk("run_ret", Retired, k / 4);
    end

    // hold three instructions at PC=4
    PCHold = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("hold_pc", ProgAddr, 4);
    end
    chk("hold_ret", Retired, 4);
    chk("hold_instr", Instruction, 104);
    PCHold = 1'b0;
    repeat (4) tick();
    chk("release_pc", ProgAddr, 5);
    chk("release_ret", Retired, 5);

    // hold asserted only in stages 0-2 is ignored
    PCHold = 1'b1;
    repeat (3) tick();
    chk("ign_stage", Stage, 3);
    PCHold = 1'b0;
    tick();
    chk("ign_pc", ProgAddr, 6);
    chk("ign_ret", Retired, 6);

    // synchroniser latency of two edges
    HandshakeIn = 1'b1;
    tick();
    chk("hs_lat1", Handshake, 0);
    tick();
    chk("hs_lat2", Handshake, 1);
    HandshakeIn = 1'b0;
    tick();
    chk("hs_fall1", Handshake, 1);
    tick();
    chk("hs_fall2", Handshake, 0);
    chk("pre_rst_pc", ProgAddr, 7);
    chk("pre_rst_stage", Stage, 0);

    // reset during Stage 2 at PC=7 with Handshake high
    HandshakeIn = 1'b1;
    tick(); tick();
    chk("mid_stage", Stage, 2);
    chk("mid_hs", Handshake, 1);
    chk("mid_instr", Instruction, 107);
    reset = 1'b1; PCHold = 1'b1;
    tick();
    chk("mrst_stage", Stage, 0);
    chk("mrst_pc", ProgAddr, 0);
    chk("mrst_instr", Instruction, 0);
    chk("mrst_hs", Handshake, 0);
    chk("mrst_ret", Retired, 0);
    chk("mrst_wrap", Wrap, 0);
    reset = 1'b0; PCHold = 1'b0; HandshakeIn = 1'b0;

    // run to PC=31; Retired saturates at 15 on the way
    wrap_seen = 1'b0;
    for (int k = 1; k <= 124; k++) begin
      tick();
      wrap_seen |= Wrap;
    end
    chk("nowrap_run", wrap_seen, 0);
    chk("max_pc", ProgAddr, 31);
    chk("sat_ret", Retired, 15);
    repeat (3) tick();
    chk("wb_wrap", Wrap, 0);
    tick();
    chk("wrap_pc", ProgAddr, 0);
    chk("wrap_pulse", Wrap, 1);
    tick();
    chk("wrap_clear", Wrap, 0);
    chk("sat_hold", Retired, 15);
    chk("wrap_instr", Instruction, 100);

    // hold at PC=31 must not wrap
    repeat (123) tick();
    chk("max_pc2", ProgAddr, 31);
    chk("max_stage2", Stage, 0);
    PCHold = 1'b1;
    wrap_seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      wrap_seen |= Wrap;
    end
    chk("hold_max_pc", ProgAddr, 31);
    chk("hold_nowrap", wrap_seen, 0);
    PCHold = 1'b0;
    repeat (4) tick();
    chk("wrap2_pc", ProgAddr, 0);
    chk("wrap2_pulse", Wrap, 1);
    chk("sat_end", Retired, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
